// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_WAIT, ARB_RESP} arb_state_t;
    typedef enum logic {PORT_C, PORT_D} arb_port_t;

    localparam int RD_LAT_MAX = 7;
    localparam int WAIT_W     = $clog2(RD_LAT_MAX + 1);

    // Port that the round-robin would favour after the given winner.
    function automatic arb_port_t other_port(input arb_port_t p);
        return (p == PORT_C) ? PORT_D : PORT_C;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way combinational round-robin pick. Bit 0 is port C, bit 1 is port D.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  arb_port_t  last_grant,
    output logic [1:0] gnt
);

    // A lone requester always wins; a tie goes to the port that did not win last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (other_port(last_grant) == PORT_C) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (port C) and a debug
// loader (port D). Each grant runs IDLE -> ACCESS -> {WAIT} -> RESP -> IDLE.
// Optional statistics counters are built only when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW     = 32,
    parameter int RD_LAT = 1,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req_valid,
    output logic          c_req_ready,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wdata,
    input  logic [3:0]    c_we,
    output logic          c_rsp_valid,
    output logic [31:0]   c_rdata,
    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_we,
    output logic          d_rsp_valid,
    output logic [31:0]   d_rdata,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_we,
    input  logic [31:0]   mem_rdata,
    output logic [CW-1:0] grant_cnt_c,
    output logic [CW-1:0] grant_cnt_d,
    output logic [CW-1:0] conflict_cnt
);

    localparam logic [WAIT_W-1:0] LP_WAIT_INIT = WAIT_W'(RD_LAT - 1);
    localparam logic [WAIT_W-1:0] LP_WAIT_ONE  = WAIT_W'(1);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    arb_port_t         r_port;
    arb_port_t         r_last_grant;
    logic [AW-1:0]     r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_we;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [31:0]       r_c_rdata;
    logic [31:0]       r_d_rdata;
    logic              r_c_rsp_valid;
    logic              r_d_rsp_valid;
    logic [1:0]        w_gnt;
    logic              w_accept;
    logic              w_is_write;
    logic              w_write_done;
    logic              w_read_done;

    rr_arb2 u_rr_arb2 (
        .req        ({d_req_valid, c_req_valid}),
        .last_grant (r_last_grant),
        .gnt        (w_gnt)
    );

    assign w_is_write  = |r_we;
    assign c_rsp_valid = r_c_rsp_valid;
    assign d_rsp_valid = r_d_rsp_valid;
    assign c_rdata     = r_c_rdata;
    assign d_rdata     = r_d_rdata;

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ARB_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state: single ACCESS cycle, optional read wait, single RESP cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE:   if (w_accept) w_next_state = ARB_ACCESS;
            ARB_ACCESS: begin
                if (w_is_write || (RD_LAT == 1)) w_next_state = ARB_RESP;
                else                             w_next_state = ARB_WAIT;
            end
            ARB_WAIT:   if (r_wait_cnt <= LP_WAIT_ONE) w_next_state = ARB_RESP;
            ARB_RESP:   w_next_state = ARB_IDLE;
            default:    w_next_state = ARB_IDLE;
        endcase
    end

    // Outputs: ready only in IDLE, memory strobes only in ACCESS.
    // A write completes when its ACCESS cycle ends; a read when RESP captures data.
    always_comb begin
        c_req_ready  = (r_state == ARB_IDLE) && w_gnt[0] && reset;
        d_req_ready  = (r_state == ARB_IDLE) && w_gnt[1] && reset;
        w_accept     = c_req_ready || d_req_ready;
        mem_en       = (r_state == ARB_ACCESS);
        mem_we       = (r_state == ARB_ACCESS) ? r_we : 4'b0000;
        mem_addr     = r_addr;
        mem_wdata    = r_wdata;
        w_write_done = (r_state == ARB_ACCESS) && w_is_write;
        w_read_done  = (r_state == ARB_RESP) && !w_is_write;
    end

    // Latch the winning request and remember who won for the next tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= '0;
            r_port       <= PORT_C;
            r_last_grant <= PORT_D;
        end else if (w_accept) begin
            r_addr       <= w_gnt[1] ? d_addr  : c_addr;
            r_wdata      <= w_gnt[1] ? d_wdata : c_wdata;
            r_we         <= w_gnt[1] ? d_we    : c_we;
            r_port       <= w_gnt[1] ? PORT_D  : PORT_C;
            r_last_grant <= w_gnt[1] ? PORT_D  : PORT_C;
        end
    end

    // Read wait counter: loaded in ACCESS, counted down through WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == ARB_ACCESS && !w_is_write) begin
            r_wait_cnt <= LP_WAIT_INIT;
        end else if (r_state == ARB_WAIT) begin
            r_wait_cnt <= r_wait_cnt - LP_WAIT_ONE;
        end
    end

    // Response pulse and per-port read-data capture; rdata holds across writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c_rsp_valid <= 1'b0;
            r_d_rsp_valid <= 1'b0;
            r_c_rdata     <= '0;
            r_d_rdata     <= '0;
        end else begin
            r_c_rsp_valid <= (w_write_done || w_read_done) && (r_port == PORT_C);
            r_d_rsp_valid <= (w_write_done || w_read_done) && (r_port == PORT_D);
            if (w_read_done && r_port == PORT_C) r_c_rdata <= mem_rdata;
            if (w_read_done && r_port == PORT_D) r_d_rdata <= mem_rdata;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [CW-1:0] r_grant_cnt_c;
    logic [CW-1:0] r_grant_cnt_d;
    logic [CW-1:0] r_conflict_cnt;

    // Saturating grant and conflict statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant_cnt_c  <= '0;
            r_grant_cnt_d  <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (c_req_ready && r_grant_cnt_c != '1) r_grant_cnt_c <= r_grant_cnt_c + CW'(1);
            if (d_req_ready && r_grant_cnt_d != '1) r_grant_cnt_d <= r_grant_cnt_d + CW'(1);
            if ((r_state == ARB_IDLE) && c_req_valid && d_req_valid && r_conflict_cnt != '1)
                r_conflict_cnt <= r_conflict_cnt + CW'(1);
        end
    end

    assign grant_cnt_c  = r_grant_cnt_c;
    assign grant_cnt_d  = r_grant_cnt_d;
    assign conflict_cnt = r_conflict_cnt;
`else
    assign grant_cnt_c  = '0;
    assign grant_cnt_d  = '0;
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter, with a transaction-level
// arbitration/memory model, a memory responder and a mid-access reset case.
module tb_dmem_arbiter;

   localparam int AW      = 32;
   localparam int RD_LAT  = 3;
   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   typedef struct {int cyc; int port; bit isRead; logic [31:0] data;} rsp_t;
   typedef struct {int cyc; logic [31:0] addr; logic [31:0] wdata; logic [3:0] we;} acc_t;
   typedef struct {int cyc; logic [31:0] data;} rd_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic reqValid [2];
   logic [31:0] reqAddr [2];
   logic [31:0] reqWdata [2];
   logic [3:0] reqWe [2];
   logic cReady, dReady, cRspValid, dRspValid, memEn;
   logic [31:0] cRdata, dRdata, memAddr, memWdata;
   logic [31:0] memRdata = 32'h0;
   logic [3:0] memWe;
   logic [CW-1:0] grantCntC, grantCntD, conflictCnt;

   rsp_t rspQ[$];
   acc_t accQ[$];
   rd_t  rdQ[$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [31:0] respMem [8];
   logic [31:0] refMem [8];
   logic [31:0] heldRdata [2];
   bit mLastC;
   int mFreeCyc;
   int mGrant [2];
   int mConflict;
   bit accepted [2];
   bit allowNew;

   dmem_arbiter #(.AW(AW), .RD_LAT(RD_LAT), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .c_req_valid(reqValid[0]), .c_req_ready(cReady), .c_addr(reqAddr[0]),
      .c_wdata(reqWdata[0]), .c_we(reqWe[0]), .c_rsp_valid(cRspValid), .c_rdata(cRdata),
      .d_req_valid(reqValid[1]), .d_req_ready(dReady), .d_addr(reqAddr[1]),
      .d_wdata(reqWdata[1]), .d_we(reqWe[1]), .d_rsp_valid(dRspValid), .d_rdata(dRdata),
      .mem_en(memEn), .mem_addr(memAddr), .mem_wdata(memWdata), .mem_we(memWe),
      .mem_rdata(memRdata),
      .grant_cnt_c(grantCntC), .grant_cnt_d(grantCntD), .conflict_cnt(conflictCnt)
   );

   // free-running clock and cycle index
   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   task automatic newReq(input int p);
      reqValid[p] = 1'b1;
      reqAddr[p]  = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      reqWdata[p] = $urandom;
      reqWe[p]    = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
   endtask

   task automatic resetModel();
      mLastC    = 1'b0;
      mFreeCyc  = cyc;
      mGrant[0] = 0;
      mGrant[1] = 0;
      mConflict = 0;
      heldRdata[0] = 32'h0;
      heldRdata[1] = 32'h0;
      rspQ.delete();
      accQ.delete();
   endtask

   // one cycle: model arbitration at negedge, then update requesters after the edge
   task automatic applyStimulus();
      int g;
      bit isRead;
      int idx;
      logic [31:0] d;
      @(negedge clk);
      accepted[0] = 1'b0;
      accepted[1] = 1'b0;
`ifdef DMEM_ARB_STATS_EN
      checkOutput("grant_cnt_c", 32'(grantCntC), 32'(mGrant[0]));
      checkOutput("grant_cnt_d", 32'(grantCntD), 32'(mGrant[1]));
      checkOutput("conflict_cnt", 32'(conflictCnt), 32'(mConflict));
`else
      checkOutput("grant_cnt_c", 32'(grantCntC), 32'h0);
      checkOutput("grant_cnt_d", 32'(grantCntD), 32'h0);
      checkOutput("conflict_cnt", 32'(conflictCnt), 32'h0);
`endif
      g = -1;
      if (reset && cyc >= mFreeCyc) begin
         if (reqValid[0] && reqValid[1]) begin
            g = mLastC ? 1 : 0;
            if (mConflict < CNT_MAX) mConflict++;
         end else if (reqValid[0]) g = 0;
         else if (reqValid[1]) g = 1;
      end
      checkOutput("ready_c", 32'(cReady), 32'(g == 0));
      checkOutput("ready_d", 32'(dReady), 32'(g == 1));
      if (g >= 0) begin
         isRead = (reqWe[g] == 4'b0000);
         idx = int'(reqAddr[g][4:2]);
         accQ.push_back('{cyc + 1, reqAddr[g], reqWdata[g], reqWe[g]});
         if (isRead) d = refMem[idx];
         else begin
            refMem[idx] = mergeBytes(refMem[idx], reqWdata[g], reqWe[g]);
            d = 32'h0;
         end
         rspQ.push_back('{isRead ? cyc + 2 + RD_LAT : cyc + 2, g, isRead, d});
         mFreeCyc = isRead ? cyc + 2 + RD_LAT : cyc + 3;
         mLastC = (g == 0);
         if (mGrant[g] < CNT_MAX) mGrant[g]++;
         accepted[g] = 1'b1;
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
         if (accepted[p]) begin
            reqValid[p] = 1'b0;
            if (allowNew && $urandom_range(0, 1) == 0) newReq(p);
         end else if (!reqValid[p] && allowNew && $urandom_range(0, 2) == 0) begin
            newReq(p);
         end
      end
   endtask

   // memory responder: applies writes, returns read data RD_LAT cycles after mem_en
   initial forever begin
      @(negedge clk);
      if (memEn) begin
         if (memWe != 4'b0000) respMem[memAddr[4:2]] = mergeBytes(respMem[memAddr[4:2]], memWdata, memWe);
         else rdQ.push_back('{cyc + RD_LAT, respMem[memAddr[4:2]]});
      end
      while (rdQ.size() != 0 && rdQ[0].cyc < cyc) void'(rdQ.pop_front());
      if (rdQ.size() != 0 && rdQ[0].cyc == cyc) memRdata = rdQ.pop_front().data;
      else memRdata = $urandom;
   end

   // monitor: responses and memory accesses against the scoreboard queues
   initial forever begin
      rsp_t e;
      acc_t a;
      logic [31:0] act;
      @(negedge clk);
      while (rspQ.size() != 0 && rspQ[0].cyc < cyc) begin
         e = rspQ.pop_front();
         checkOutput("rsp_missing", 32'(e.cyc), 32'(cyc));
      end
      if (cRspValid || dRspValid) begin
         if (rspQ.size() == 0 || rspQ[0].cyc != cyc) begin
            checkOutput("rsp_unexpected", {30'h0, dRspValid, cRspValid}, 32'h0);
         end else begin
            e = rspQ.pop_front();
            checkOutput("rsp_port", {30'h0, dRspValid, cRspValid}, 32'(1) << e.port);
            act = (e.port == 0) ? cRdata : dRdata;
            if (e.isRead) heldRdata[e.port] = e.data;
            checkOutput(e.isRead ? "rdata_read" : "rdata_hold", act, heldRdata[e.port]);
         end
      end
      if (accQ.size() != 0 && accQ[0].cyc == cyc) begin
         a = accQ.pop_front();
         checkOutput("mem_en", 32'(memEn), 32'h1);
         checkOutput("mem_addr", memAddr, a.addr);
         checkOutput("mem_wdata", memWdata, a.wdata);
         checkOutput("mem_we", 32'(memWe), 32'(a.we));
      end else begin
         checkOutput("mem_idle", {27'h0, memWe, memEn}, 32'h0);
      end
   end

   initial begin
      int n;
      for (int i = 0; i < 8; i++) begin
         respMem[i] = 32'hA5A5_0000 + 32'(i) * 32'h0101;
         refMem[i]  = respMem[i];
      end
      for (int p = 0; p < 2; p++) begin
         reqValid[p] = 1'b0; reqAddr[p] = 32'h0; reqWdata[p] = 32'h0; reqWe[p] = 4'h0;
      end
      allowNew = 1'b0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_mem_en", 32'(memEn), 32'h0);
      checkOutput("rst_mem_addr", memAddr, 32'h0);
      checkOutput("rst_rsp", {30'h0, dRspValid, cRspValid}, 32'h0);
      checkOutput("rst_rdata_c", cRdata, 32'h0);
      checkOutput("rst_rdata_d", dRdata, 32'h0);
      checkOutput("rst_cnts", {20'h0, grantCntC, grantCntD, conflictCnt}, 32'h0);
      reset = 1'b1;
      resetModel();

      $display("[TB] random traffic phase");
      allowNew = 1'b1;
      repeat (400) applyStimulus();
      allowNew = 1'b0;
      n = 0;
      while ((rspQ.size() != 0 || reqValid[0] || reqValid[1]) && n < 300) begin
         applyStimulus();
         n++;
      end
      checkOutput("drain_timeout", 32'(n >= 300), 32'h0);

      $display("[TB] reset during read wait");
      reqValid[0] = 1'b1; reqAddr[0] = 32'h110; reqWe[0] = 4'b0000; reqWdata[0] = 32'h0;
      n = 0;
      while (!accepted[0] && n < 20) begin
         applyStimulus();
         n++;
      end
      checkOutput("mid_accept_timeout", 32'(n >= 20), 32'h0);
      applyStimulus();
      reset = 1'b0;
      #1;
      checkOutput("mid_rst_mem_en", {27'h0, memWe, memEn}, 32'h0);
      checkOutput("mid_rst_ready", {30'h0, dReady, cReady}, 32'h0);
      resetModel();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      resetModel();
      reqValid[0] = 1'b1; reqAddr[0] = 32'h104; reqWe[0] = 4'b0000;
      reqValid[1] = 1'b1; reqAddr[1] = 32'h118; reqWe[1] = 4'b0000;
      applyStimulus();
      checkOutput("post_rst_tie_c", 32'(accepted[0]), 32'h1);
      n = 0;
      while ((rspQ.size() != 0 || reqValid[0] || reqValid[1]) && n < 100) begin
         applyStimulus();
         n++;
      end
      checkOutput("final_drain_timeout", 32'(n >= 100), 32'h0);
      repeat (2) applyStimulus();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
